// File: rtl/fp_absmax_scan_if.sv
// Handshake/data bundle for the fp_absmax_scan max-magnitude reduction stage.
// The master modport is the producer/consumer side; the slave modport is the scan stage.
interface fp_absmax_scan_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_max;
    logic [CNT_W-1:0] out_idx;
    logic             out_nan;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_nan, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_nan, busy
    );
endinterface

// File: rtl/fp_absmax_scan.sv
// Streaming max-magnitude reduction over a block of single-precision |x| samples.
// Define FP_ABSMAX_DENORM_FLUSH_EN to make denormal samples compare as +0.0.
module fp_absmax_scan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_absmax_scan_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [31:0]      max_q, max_d;
    logic             nan_q, nan_d;

    logic [31:0]      sample_mag;
    logic [31:0]      sample_cmp;
    logic             sample_nan;
    logic             sample_zero_exp;

    // Sign is masked off, so unsigned order of the remaining bits is magnitude order.
    always_comb begin
        sample_mag      = bus.in_data & 32'h7FFF_FFFF;
        sample_nan      = (sample_mag[30:23] == 8'hFF) && (sample_mag[22:0] != 23'd0);
        sample_zero_exp = (sample_mag[30:23] == 8'h00);
`ifdef FP_ABSMAX_DENORM_FLUSH_EN
        sample_cmp      = sample_zero_exp ? 32'd0 : sample_mag;
`else
        sample_cmp      = sample_mag;
`endif
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        idx_d   = idx_q;
        max_d   = max_q;
        nan_d   = nan_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    count_d = '0;
                    idx_d   = '0;
                    max_d   = 32'd0;
                    nan_d   = 1'b0;
                    state_d = (bus.len == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                // in_ready is high for the whole of SCAN, so in_valid alone is an accept.
                if (bus.in_valid) begin
                    if (sample_nan) begin
                        nan_d = 1'b1;
                    end else if (sample_cmp > max_q) begin
                        max_d = sample_cmp;
                        idx_d = count_q;
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_q == len_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            max_q   <= 32'd0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            nan_q   <= nan_d;
        end
    end

    assign bus.in_ready  = (state_q == SCAN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_max   = max_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_nan   = nan_q;

endmodule

// File: tb/tb_fp_absmax_scan.sv
// Directed, table-driven bench for fp_absmax_scan plus hand-written DONE-hold,
// zero-length and mid-scan async reset sequences.
module tb_fp_absmax_scan;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [CNT_W-1:0] len;
        logic [3:0][31:0] data;
        logic [31:0]      expMax;
        logic [CNT_W-1:0] expIdx;
        logic             expNan;
    } vec_t;

    logic clk;
    logic rst_n;
    int   numChecks;
    int   numFails;

    fp_absmax_scan_if #(.CNT_W(CNT_W)) bus ();

    fp_absmax_scan #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [CNT_W-1:0] l,
                                   input logic [31:0] d0, input logic [31:0] d1,
                                   input logic [31:0] d2, input logic [31:0] d3,
                                   input logic [31:0] m, input logic [CNT_W-1:0] i,
                                   input logic n);
        vec_t v;
        v.len     = l;
        v.data[0] = d0;
        v.data[1] = d1;
        v.data[2] = d2;
        v.data[3] = d3;
        v.expMax  = m;
        v.expIdx  = i;
        v.expNan  = n;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        numChecks++;
        if (act !== expv) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic recoverReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one block; call at #1 after a posedge with the stage in IDLE.
    task automatic applyStimulus(input vec_t v, input string tag, input bit doHandshake);
        bus.start = 1'b1;
        bus.len   = v.len;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < int'(v.len); i++) begin
            checkOutput({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = v.data[i];
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checkOutput({tag, " out_valid latency"}, {31'd0, bus.out_valid}, 32'd1);
        if (!bus.out_valid) begin
            for (int c = 0; c < 20 && !bus.out_valid; c++) begin
                @(posedge clk);
                #1;
            end
            if (!bus.out_valid) begin
                numChecks++;
                numFails++;
                $display("[TB] FAIL %s timeout: out_valid still 0 after 20 cycles, expected 1", tag);
                recoverReset();
                return;
            end
        end
        checkOutput({tag, " out_max"}, bus.out_max, v.expMax);
        checkOutput({tag, " out_idx"}, {16'd0, bus.out_idx}, {16'd0, v.expIdx});
        checkOutput({tag, " out_nan"}, {31'd0, bus.out_nan}, {31'd0, v.expNan});
        if (doHandshake) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            checkOutput({tag, " out_valid after take"}, {31'd0, bus.out_valid}, 32'd0);
        end
    endtask

    vec_t vecs [10];
    vec_t holdVec;
    vec_t rstVec;

    initial begin
        numChecks     = 0;
        numFails      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;

        vecs[0] = mkVec(16'd4, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40400000, 32'h40400000, 16'd1, 1'b0);
        vecs[1] = mkVec(16'd3, 32'h3F000000, 32'h7FC00000, 32'h3E800000, 32'h0, 32'h3F000000, 16'd0, 1'b1);
        vecs[2] = mkVec(16'd2, 32'hBF800000, 32'h7F800000, 32'h0, 32'h0, 32'h7F800000, 16'd1, 1'b0);
`ifdef FP_ABSMAX_DENORM_FLUSH_EN
        vecs[3] = mkVec(16'd2, 32'h00000000, 32'h00000001, 32'h0, 32'h0, 32'h00000000, 16'd0, 1'b0);
        vecs[4] = mkVec(16'd3, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0, 32'h00000000, 16'd0, 1'b0);
`else
        vecs[3] = mkVec(16'd2, 32'h00000000, 32'h00000001, 32'h0, 32'h0, 32'h00000001, 16'd1, 1'b0);
        vecs[4] = mkVec(16'd3, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0, 32'h00000005, 16'd0, 1'b0);
`endif
        vecs[5] = mkVec(16'd1, 32'h7F800000, 32'h0, 32'h0, 32'h0, 32'h7F800000, 16'd0, 1'b0);
        vecs[6] = mkVec(16'd3, 32'h40A00000, 32'h40A00000, 32'hC0A00000, 32'h0, 32'h40A00000, 16'd0, 1'b0);
        vecs[7] = mkVec(16'd4, 32'hFFC00001, 32'h7FFFFFFF, 32'h3F800000, 32'hFF800000, 32'h7F800000, 16'd3, 1'b1);
        vecs[8] = mkVec(16'd2, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h00000000, 16'd0, 1'b0);
        vecs[9] = mkVec(16'd4, 32'h00000001, 32'h3F800000, 32'h3F800001, 32'h3F800001, 32'h3F800001, 16'd2, 1'b0);
        holdVec = mkVec(16'd2, 32'h3F800000, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 16'd1, 1'b0);
        rstVec  = mkVec(16'd1, 32'h40000000, 32'h0, 32'h0, 32'h0, 32'h40000000, 16'd0, 1'b0);

        #12;
        checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset out_max", bus.out_max, 32'd0);
        checkOutput("reset out_idx", {16'd0, bus.out_idx}, 32'd0);
        checkOutput("reset out_nan", {31'd0, bus.out_nan}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k], $sformatf("vec%0d", k), 1'b1);
        end

        // Zero-length block goes straight to DONE with a cleared result.
        bus.start = 1'b1;
        bus.len   = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("len0 out_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("len0 in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("len0 out_max", bus.out_max, 32'd0);
        checkOutput("len0 out_idx", {16'd0, bus.out_idx}, 32'd0);
        checkOutput("len0 out_nan", {31'd0, bus.out_nan}, 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("len0 idle", {31'd0, bus.busy}, 32'd0);

        // Hold DONE while hammering start and in_valid.
        applyStimulus(holdVec, "hold", 1'b0);
        for (int c = 0; c < 5; c++) begin
            bus.start    = 1'b1;
            bus.len      = 16'd3;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h7F800000;
            @(posedge clk);
            #1;
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            checkOutput("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
            checkOutput("hold out_max", bus.out_max, 32'h40000000);
            checkOutput("hold out_idx", {16'd0, bus.out_idx}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("hold released busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("hold released out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset in the middle of a scan.
        bus.start = 1'b1;
        bus.len   = 16'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i == 0) ? 32'h40400000 : 32'h40800000;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checkOutput("midscan busy", {31'd0, bus.busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst out_max", bus.out_max, 32'd0);
        checkOutput("async rst busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("async rst in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("async rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(rstVec, "after reset", 1'b1);

        $display("%0d/%0d checks passed", numChecks - numFails, numChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
